muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide engine with the architectural HI/LO register pair.
- Executes MULT/MULTU/DIV/DIVU issued from EX. The pipeline consumes busy as its stall source for MFHI/MFLO and later muldiv ops.
- Also services MTHI/MTLO writes.
- Replaces the single-cycle combinational multiply/divide path, so that path no longer limits cycle time.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine owning the HI/LO pair.
// One radix-2 iteration per cycle over a shared 2*WIDTH work register.
// Results are sign-corrected in a final FIX cycle and written to HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     count_reg;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0]   acc_reg;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     operand_reg;
    logic                 is_div_reg;
    logic                 neg_res_reg;
    logic                 neg_rem_reg;
    logic                 div_zero_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;

    // Operand decode and magnitude extraction at issue
    logic                 signed_op;
    logic [WIDTH-1:0]     abs_x;
    logic [WIDTH-1:0]     abs_y;

    // One iteration of each algorithm
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   div_next;

    // Sign-corrected results for the FIX cycle
    logic [2*WIDTH-1:0]   product_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Issue-side decode: signed ops take magnitudes; 0x80000000 stays 0x80000000 unsigned
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        abs_x     = (signed_op && X[WIDTH-1]) ? -X : X;
        abs_y     = (signed_op && Y[WIDTH-1]) ? -Y : Y;
    end

    // Shift-add multiply step and restoring shift-subtract divide step
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, operand_reg} : '0);
        mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};

        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand_reg};
        if (rem_diff[WIDTH]) begin
            div_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction; divide by zero forces an all-ones quotient
    always_comb begin
        product_fix = neg_res_reg ? -acc_reg : acc_reg;
        quot_fix    = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        if (div_zero_reg) begin
            quot_fix = '1;
        end
        rem_fix     = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO architectural state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            operand_reg  <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_reg   <= op[1];
                                neg_res_reg  <= signed_op && (X[WIDTH-1] ^ Y[WIDTH-1]);
                                neg_rem_reg  <= signed_op && X[WIDTH-1];
                                div_zero_reg <= op[1] && (Y == '0);
                                operand_reg  <= op[1] ? abs_y : abs_x;
                                acc_reg      <= {{WIDTH{1'b0}}, (op[1] ? abs_x : abs_y)};
                                count_reg    <= CNT_W'(WIDTH);
                                busy_reg     <= 1'b1;
                                state_reg    <= CALC;
                            end
                            OP_MTHI: hi_reg <= X;
                            OP_MTLO: lo_reg <= X;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (cancel) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= is_div_reg ? div_next : mul_next;
                        count_reg <= count_reg - CNT_W'(1);
                        if (count_reg == CNT_W'(1)) begin
                            state_reg <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (!cancel) begin
                        done_reg <= 1'b1;
                        if (is_div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end else begin
                            hi_reg <= product_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= product_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, expected HI/LO pushed into a
// scoreboard queue at issue and checked by a monitor on every done pulse.
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [$];
    string       name_q [$];

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .X      (X),
        .Y      (Y),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", name, actual);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        logic [63:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 HI=0x%0h LO=0x%0h expected no done", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check({n, "_hilo"}, {HI, LO}, e);
                    check({n, "_busy_low"}, {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    // Present an issue for one cycle; called at a negedge, returns at the next negedge
    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        X     = x;
        Y     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
    endtask

    task automatic expect_result(input string name, input logic [31:0] hi, input logic [31:0] lo);
        exp_q.push_back({hi, lo});
        name_q.push_back(name);
    endtask

    // Count busy cycles until done (bounded); returns at the negedge of the done cycle
    task automatic wait_done(input string name);
        int  nbusy = 0;
        int  cyc   = 0;
        bit  seen  = 0;
        while (!seen && cyc < 100) begin
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (busy === 1'b1) nbusy++;
                cyc++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
        check({name, "_busy_cycles"}, 64'(nbusy), 64'd33);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] hi, input logic [31:0] lo);
        expect_result(name, hi, lo);
        drive(o, x, y);
        wait_done(name);
    endtask

    initial begin
        int ndone;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'd7;
        X      = '0;
        Y      = '0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult_7_m3",   3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge clk);
        run_op("multu_max",   3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        run_op("div_m7_2",    3'd2, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        @(negedge clk);
        run_op("div_ovf",     3'd2, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        @(negedge clk);
        run_op("divu_by0",    3'd3, 32'd100,        32'd0,        32'h00000064, 32'hFFFFFFFF);
        @(negedge clk);
        run_op("div_m7_by0",  3'd2, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        @(negedge clk);
        run_op("div_7_m2",    3'd2, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        @(negedge clk);
        run_op("mult_min_m1", 3'd0, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        @(negedge clk);

        // MTLO: visible next cycle, no busy; HI keeps 0 from the previous product
        drive(3'd5, 32'h00001234, 32'd0);
        check("mtlo_lo",   {32'd0, LO}, 64'h1234);
        check("mtlo_hi",   {32'd0, HI}, 64'h0);
        check("mtlo_busy", {63'd0, busy}, 64'd0);

        // MULT 5*5, MTHI while busy (ignored), cancel at cycle 10
        drive(3'd0, 32'd5, 32'd5);
        drive(3'd4, 32'h0000DEAD, 32'd0);
        repeat (7) @(negedge clk);
        check("pre_cancel_busy", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_hilo", {HI, LO}, {32'h0, 32'h1234});
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("cancel_no_done", 64'(ndone), 64'd0);

        // cancel together with MTHI in IDLE: nothing accepted
        cancel = 1'b1;
        drive(3'd4, 32'h00005555, 32'd0);
        cancel = 1'b0;
        check("cancel_mthi_hi", {32'd0, HI}, 64'h0);

        // reserved op: ignored
        drive(3'd6, 32'h00007777, 32'd3);
        check("op6_busy", {63'd0, busy}, 64'd0);
        check("op6_hilo", {HI, LO}, {32'h0, 32'h1234});

        // MTHI accepted in IDLE
        drive(3'd4, 32'h0000ABCD, 32'd0);
        check("mthi_hi", {HI, LO}, {32'h0000ABCD, 32'h1234});

        // reset at cycle 20 of a DIVU
        drive(3'd3, 32'd1000, 32'd7);
        repeat (18) @(negedge clk);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_hilo", {HI, LO}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);

        // back-to-back: MULTU issued in the done cycle of a DIVU
        run_op("divu_1000_7", 3'd3, 32'd1000, 32'd7, 32'd6, 32'd142);
        run_op("b2b_multu",   3'd1, 32'd3,    32'd4, 32'd0, 32'd12);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
